tpu_ctrl_pio: RTL and testbench

Parametrised Avalon-MM control port that drives the TPU datapath from the host processor. It extends the single 32-bit output register with NUM_CH byte-enabled output channels and a DEPTH-entry command FIFO that drains to the fabric over a valid/ready handshake. It also provides a saturating completion counter fed by the fabric, and an optional completion interrupt. It sits on the processor's Avalon bus, with its outputs wired straight into the TPU control logic.

---
 rtl/tpu_ctrl_pio.sv | 178 +++++++++++++++++
 tb/tb_tpu_ctrl_pio.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tpu_ctrl_pio.sv
// Avalon-MM control port: byte-enabled channels, command FIFO, done counter.
// Optional completion interrupt built when TPU_CTRL_PIO_IRQ_EN is defined.
module tpu_ctrl_pio #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int AW = $clog2(NUM_CH + 4),
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [AW-1:0]                address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [BW-1:0]                byteenable,
  input  logic [DATA_WIDTH-1:0]        writedata,
  output logic [DATA_WIDTH-1:0]        readdata,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic                         cmd_valid,
  output logic [DATA_WIDTH-1:0]        cmd_data,
  input  logic                         cmd_ready,
  input  logic                         done,
  output logic                         irq
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] A_CMD = AW'(NUM_CH);
  localparam logic [AW-1:0] A_STS = AW'(NUM_CH + 1);
  localparam logic [AW-1:0] A_CNT = AW'(NUM_CH + 2);

  logic [DATA_WIDTH-1:0] ch_q [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_d [NUM_CH];
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;

  logic wr, wr_cmd, wr_sts, wr_cnt;
  logic empty, full, pop, push_ok, ovf_set;
  logic irq_pend;

  assign wr     = chipselect & ~write_n;
  assign wr_cmd = wr & (address == A_CMD);
  assign wr_sts = wr & (address == A_STS);
  assign wr_cnt = wr & (address == A_CNT);

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign cmd_valid = ~empty;
  assign cmd_data  = mem_q[rd_ptr_q];
  assign pop       = cmd_valid & cmd_ready;
  // A pop frees a slot in the same edge, so a full FIFO still accepts.
  assign push_ok   = wr_cmd & (~full | pop);
  assign ovf_set   = wr_cmd & ~push_ok;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_d[k] = ch_q[k];
      if (wr && address == AW'(k)) begin
        for (int b = 0; b < BW; b++) begin
          if (byteenable[b]) ch_d[k][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = writedata;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_sts && writedata[18]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    cnt_d = cnt_q;
    if (done && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (wr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= RESET_VALUE;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ch_q     <= ch_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef TPU_CTRL_PIO_IRQ_EN
  localparam logic [AW-1:0] A_IRQ = AW'(NUM_CH + 3);

  logic wr_irq;
  logic en_q, en_d;
  logic pend_q, pend_d;
  logic irq_q, irq_d;

  assign wr_irq = wr & (address == A_IRQ);

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    if (wr_irq) begin
      en_d = writedata[0];
      if (writedata[1]) pend_d = 1'b0;
    end
    if (done) pend_d = 1'b1;
    // Registered so irq never glitches between enable and pending updates.
    irq_d = en_d & pend_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq      = irq_q;
  assign irq_pend = pend_q;
`else
  assign irq      = 1'b0;
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      out_port[k*DATA_WIDTH +: DATA_WIDTH] = ch_q[k];
    end
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (address == AW'(k)) readdata = ch_q[k];
    end
    if (address == A_STS) begin
      readdata[LW-1:0] = level_q;
      readdata[16]     = empty;
      readdata[17]     = full;
      readdata[18]     = ovf_q;
      readdata[19]     = irq_pend;
    end
    if (address == A_CNT) readdata[15:0] = cnt_q;
`ifdef TPU_CTRL_PIO_IRQ_EN
    if (address == A_IRQ) readdata[1:0] = {pend_q, en_q};
`endif
  end

endmodule

// File: tb/tb_tpu_ctrl_pio.sv
// Directed bench for tpu_ctrl_pio with a scoreboard queue on the command FIFO.
// Interrupt checks follow TPU_CTRL_PIO_IRQ_EN.
module tb_tpu_ctrl_pio;

  localparam int NCH = 4;
  localparam int DEP = 4;
  localparam logic [31:0] RV = 32'h0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [3:0]   byteenable = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [127:0] out_port;
  logic         cmd_valid;
  logic [31:0]  cmd_data;
  logic         cmd_ready = 1'b0;
  logic         done = 1'b0;
  logic         irq;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb[$];
  int lvl = 0;
  bit ovf_m = 0;
  logic [31:0] r;
  logic [31:0] e;

  tpu_ctrl_pio #(
    .DATA_WIDTH(32), .NUM_CH(NCH), .DEPTH(DEP), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .out_port(out_port),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the next negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] be = 4'hF, input logic dn = 1'b0);
    address = a; writedata = d; byteenable = be;
    chipselect = 1'b1; write_n = 1'b0; done = dn;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; done = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    if (lvl < DEP) begin
      sb.push_back(d);
      lvl++;
    end else begin
      ovf_m = 1'b1;
    end
    wr(3'd4, d);
  endtask

  function automatic logic [31:0] sts(input int l, input bit ovf,
                                      input bit pend);
    logic [31:0] s;
    s = 32'(l);
    s[16] = (l == 0);
    s[17] = (l == DEP);
    s[18] = ovf;
    s[19] = pend;
    return s;
  endfunction

  task automatic drain(input int cnt);
    logic [31:0] x;
    cmd_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      chk("drain_valid", cmd_valid, 1'b1);
      x = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      chk("drain_data", cmd_data, x);
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    lvl = lvl - cnt;
    chk("drain_empty", cmd_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NCH; k++) wr(3'(k), 32'h12345678);
    push(32'hDEAD);
    chk("pre_rst_out", out_port, {NCH{32'h12345678}});
    chk("pre_rst_valid", cmd_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out", out_port, {NCH{RV}});
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    sb.delete(); lvl = 0; ovf_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd5, r); chk("rst_sts", r, 32'h0001_0000);
    rd(3'd6, r); chk("rst_cnt", r, 32'h0);
    @(negedge clk);

    wr(3'd0, 32'h11223344);
    wr(3'd1, 32'hAABBCCDD, 4'b0101);
    chk("ch1_be_out", out_port[63:32], 32'h00BB00DD);
    chk("ch0_out", out_port[31:0], 32'h11223344);
    rd(3'd0, r); chk("ch0_rd", r, 32'h11223344);
    rd(3'd1, r); chk("ch1_rd", r, 32'h00BB00DD);
    rd(3'd4, r); chk("cmd_rd_zero", r, 32'h0);
    @(negedge clk);

    for (int i = 1; i <= 5; i++) push(32'(i));
    repeat (2) @(negedge clk);
    chk("hold_valid", cmd_valid, 1'b1);
    chk("hold_data", cmd_data, sb[0]);
    rd(3'd5, r); chk("full_sts", r, sts(lvl, ovf_m, 1'b0));
    chk("full_sts_lit", r, 32'h0006_0004);
    @(negedge clk);
    drain(4);
    rd(3'd5, r); chk("ovf_sts", r, sts(0, 1'b1, 1'b0));
    @(negedge clk);
    wr(3'd5, 32'h0004_0000); ovf_m = 1'b0;
    rd(3'd5, r); chk("ovf_clr", r, 32'h0001_0000);
    @(negedge clk);

    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    cmd_ready = 1'b1;
    e = sb.pop_front();
    chk("sim_head", cmd_data, e);
    sb.push_back(32'h14);
    wr(3'd4, 32'h14);
    cmd_ready = 1'b0;
    rd(3'd5, r); chk("sim_sts", r, sts(4, 1'b0, 1'b0));
    @(negedge clk);
    drain(4);

    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    rd(3'd6, r); chk("cnt3", r, 32'd3);
    @(negedge clk);
    wr(3'd6, 32'h0, 4'hF, 1'b1);
    rd(3'd6, r); chk("cnt_clr_wins", r, 32'h0);
    @(negedge clk);
    done = 1'b1;
    repeat (32'h10005) @(negedge clk);
    done = 1'b0;
    rd(3'd6, r); chk("cnt_sat", r, 32'h0000_FFFF);
    @(negedge clk);
    wr(3'd6, 32'h1234);
    rd(3'd6, r); chk("cnt_wr_clr", r, 32'h0);
    @(negedge clk);

`ifdef TPU_CTRL_PIO_IRQ_EN
    rd(3'd5, r); chk("sts_pend", r, sts(0, 1'b0, 1'b1));
    chk("irq_dis", irq, 1'b0);
    @(negedge clk);
    wr(3'd7, 32'h2);
    wr(3'd7, 32'h1);
    chk("irq_idle", irq, 1'b0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("irq_set", irq, 1'b1);
    wr(3'd7, 32'h2);
    chk("irq_clr", irq, 1'b0);
    rd(3'd7, r); chk("irqctl_clr", r, 32'h0);
    @(negedge clk);
    wr(3'd7, 32'h1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wr(3'd7, 32'h3, 4'hF, 1'b1);
    chk("irq_set_wins", irq, 1'b1);
    rd(3'd7, r); chk("irqctl_pend", r, 32'h3);
    @(negedge clk);
`else
    chk("irq_off", irq, 1'b0);
    wr(3'd7, 32'hFFFF_FFFF);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("irq_off_done", irq, 1'b0);
    rd(3'd7, r); chk("unmapped_rd", r, 32'h0);
    rd(3'd5, r); chk("sts_nopend", r, sts(0, 1'b0, 1'b0));
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
